// File: rtl/mul_arbiter.sv
// Two-port round-robin arbiter in front of one shared multiplier.
// One operation is in flight at a time; its operands are held until the response cycle.
module mul_arbiter #(
  parameter int OP_W = 3
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req0_valid,
  input  logic [31:0]     req0_factor1,
  input  logic [31:0]     req0_factor2,
  input  logic [OP_W-1:0] req0_op,
  output logic            req0_ready,
  output logic [31:0]     req0_product,
  input  logic            req1_valid,
  input  logic [31:0]     req1_factor1,
  input  logic [31:0]     req1_factor2,
  input  logic [OP_W-1:0] req1_op,
  output logic            req1_ready,
  output logic [31:0]     req1_product,
  output logic            mul_valid,
  output logic [31:0]     mul_factor1,
  output logic [31:0]     mul_factor2,
  output logic [OP_W-1:0] mul_op,
  input  logic [31:0]     mul_product,
  input  logic            mul_ready,
  output logic            busy,
  output logic            grant_id
);

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_ISSUE = 4'b0010,
    ST_WAIT  = 4'b0100,
    ST_RESP  = 4'b1000
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic            last_grant_r;
  logic            grant_r;
  logic            pick_s;
  logic            grant_en_s;
  logic            capture_s;
  logic [31:0]     fac1_r;
  logic [31:0]     fac2_r;
  logic [OP_W-1:0] op_r;
  logic [31:0]     prod0_r;
  logic [31:0]     prod1_r;
  logic            mul_valid_r;
  logic            busy_r;
  logic            ready0_r;
  logic            ready1_r;

  // Round-robin choice: on a tie the port not granted last time wins.
  always_comb begin
    pick_s = 1'b0;
    if (req0_valid && req1_valid) begin
      pick_s = ~last_grant_r;
    end else if (req1_valid) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
  end

  // Next-state and per-state strobes.
  always_comb begin
    state_nxt_s = state_r;
    grant_en_s  = 1'b0;
    capture_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req0_valid || req1_valid) begin
          state_nxt_s = ST_ISSUE;
          grant_en_s  = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (mul_ready) begin
          state_nxt_s = ST_RESP;
          capture_s   = 1'b1;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_RESP: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, grant bookkeeping, operand holding and registered strobes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r      <= ST_IDLE;
      last_grant_r <= 1'b1;
      grant_r      <= 1'b0;
      fac1_r       <= 32'd0;
      fac2_r       <= 32'd0;
      op_r         <= '0;
      mul_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      ready0_r     <= 1'b0;
      ready1_r     <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      mul_valid_r <= (state_nxt_s == ST_ISSUE);
      busy_r      <= (state_nxt_s != ST_IDLE);
      ready0_r    <= (state_nxt_s == ST_RESP) && !grant_r;
      ready1_r    <= (state_nxt_s == ST_RESP) && grant_r;
      if (grant_en_s) begin
        grant_r      <= pick_s;
        last_grant_r <= pick_s;
        fac1_r       <= pick_s ? req1_factor1 : req0_factor1;
        fac2_r       <= pick_s ? req1_factor2 : req0_factor2;
        op_r         <= pick_s ? req1_op : req0_op;
      end
    end
  end

  // Per-requester result registers; only the granted one is written.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prod0_r <= 32'd0;
      prod1_r <= 32'd0;
    end else if (capture_s) begin
      if (grant_r) begin
        prod1_r <= mul_product;
      end else begin
        prod0_r <= mul_product;
      end
    end
  end

  assign mul_valid    = mul_valid_r;
  assign mul_factor1  = fac1_r;
  assign mul_factor2  = fac2_r;
  assign mul_op       = op_r;
  assign busy         = busy_r;
  assign grant_id     = grant_r;
  assign req0_ready   = ready0_r;
  assign req1_ready   = ready1_r;
  assign req0_product = prod0_r;
  assign req1_product = prod1_r;

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: a latency-programmable multiplier model,
// directed scenarios and a randomized two-requester run against an arbitration model.
module tb_mul_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_factor1, req0_factor2, req1_factor1, req1_factor2;
  logic [2:0]  req0_op, req1_op;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_product, req1_product;
  logic        mul_valid;
  logic [31:0] mul_factor1, mul_factor2;
  logic [2:0]  mul_op;
  logic [31:0] mul_product;
  logic        mul_ready;
  logic        busy, grant_id;

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int mul_lat  = 3;
  int spur_cnt = 0;
  logic grant_log[$];

  mul_arbiter #(.OP_W(3)) dut (
    .clk(clk), .resetn(resetn),
    .req0_valid(req0_valid), .req0_factor1(req0_factor1), .req0_factor2(req0_factor2),
    .req0_op(req0_op), .req0_ready(req0_ready), .req0_product(req0_product),
    .req1_valid(req1_valid), .req1_factor1(req1_factor1), .req1_factor2(req1_factor2),
    .req1_op(req1_op), .req1_ready(req1_ready), .req1_product(req1_product),
    .mul_valid(mul_valid), .mul_factor1(mul_factor1), .mul_factor2(mul_factor2),
    .mul_op(mul_op), .mul_product(mul_product), .mul_ready(mul_ready),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // MUL=0 low word; MULH=1, MULHSU=2, MULHU=3 high word.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (op)
      3'd1:    p = sa * sb;
      3'd2:    p = sa * ub;
      default: p = ua * ub;
    endcase
    return (op == 3'd1 || op == 3'd2 || op == 3'd3) ? p[63:32] : p[31:0];
  endfunction

  // Shared multiplier model; latency 0 in mul_lat means random 1..6.
  initial begin : mul_model
    int cnt, tgt, spur_seen;
    bit pend;
    logic [31:0] res;
    cnt = 0; tgt = 0; spur_seen = 0; pend = 1'b0; res = 32'd0;
    mul_ready = 1'b0;
    mul_product = 32'd0;
    forever begin
      @(negedge clk);
      mul_ready = 1'b0;
      if (!resetn) begin
        pend = 1'b0;
        spur_seen = spur_cnt;
      end else begin
        if (spur_seen != spur_cnt) begin
          spur_seen = spur_cnt;
          mul_ready = 1'b1;
          mul_product = 32'hDEADBEEF;
        end
        if (pend) begin
          cnt++;
          if (cnt >= tgt) begin
            mul_ready = 1'b1;
            mul_product = res;
            pend = 1'b0;
          end
        end
        if (mul_valid) begin
          pend = 1'b1;
          cnt = 0;
          tgt = (mul_lat == 0) ? int'($urandom_range(1, 6)) : mul_lat;
          res = ref_mul(mul_factor1, mul_factor2, mul_op);
        end
      end
    end
  end

  initial begin : grant_logger
    forever begin
      @(negedge clk);
      if (resetn && mul_valid) grant_log.push_back(grant_id);
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic apply_reset;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  // Requester protocol: hold valid until ready, drop it the cycle after.
  task automatic serve(input int n, input logic [31:0] f1, input logic [31:0] f2,
                       input logic [2:0] op, output logic [31:0] prod, output int t_rdy,
                       output bit timed_out, output logic rdy_after);
    timed_out = 1'b1; prod = 32'd0; t_rdy = -1; rdy_after = 1'b0;
    if (n == 0) begin
      req0_factor1 = f1; req0_factor2 = f2; req0_op = op; req0_valid = 1'b1;
    end else begin
      req1_factor1 = f1; req1_factor2 = f2; req1_op = op; req1_valid = 1'b1;
    end
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if ((n == 0 && req0_ready) || (n == 1 && req1_ready)) begin
        prod = (n == 0) ? req0_product : req1_product;
        t_rdy = cyc;
        timed_out = 1'b0;
        break;
      end
    end
    @(posedge clk); #1;
    rdy_after = (n == 0) ? req0_ready : req1_ready;
    if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy, mul_valid, req0_ready, req1_ready, grant_id} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000", {busy, mul_valid, req0_ready, req1_ready, grant_id});
    end
    checks++;
    if ({req0_product, req1_product} !== 64'd0) begin
      errors++;
      $display("FAIL reset_products: got %h expected 0", {req0_product, req1_product});
    end
    checks++;
    if ({mul_factor1, mul_factor2, mul_op} !== 67'd0) begin
      errors++;
      $display("FAIL reset_operands: got %h expected 0", {mul_factor1, mul_factor2, mul_op});
    end
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    mul_lat = 34;
    req0_factor1 = 32'd7; req0_factor2 = 32'd6; req0_op = 3'd0; req0_valid = 1'b1;
    for (int k = 1; k <= 38; k++) begin
      @(posedge clk); #1;
      checks++;
      if (mul_valid !== (k == 1)) begin
        errors++;
        $display("FAIL basic_mul_valid k=%0d: got %b expected %b", k, mul_valid, (k == 1));
      end
      checks++;
      if (req0_ready !== (k == 36) || req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL basic_ready k=%0d: got %b%b expected %b0", k, req0_ready, req1_ready, (k == 36));
      end
      if (k == 1) begin
        checks++;
        if ({busy, grant_id} !== 2'b10) begin
          errors++;
          $display("FAIL basic_grant: got busy/grant %b expected 10", {busy, grant_id});
        end
      end
      if (k == 36) begin
        checks++;
        if (req0_product !== 32'd42) begin
          errors++;
          $display("FAIL basic_product: got %0d expected 42", req0_product);
        end
      end
      if (k == 37) req0_valid = 1'b0;
      if (k == 38) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL basic_idle: got busy %b expected 0", busy);
        end
      end
    end
  endtask

  task automatic test_tie;
    logic [31:0] p0, p1;
    int t0, t1, base;
    bit to0, to1;
    logic ra0, ra1;
    apply_reset();
    mul_lat = 3;
    base = grant_log.size();
    fork
      serve(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd3, p0, t0, to0, ra0);
      serve(1, 32'd3, 32'd5, 3'd0, p1, t1, to1, ra1);
    join
    checks++;
    if ({to0, to1, ra0, ra1} !== 4'b0) begin
      errors++;
      $display("FAIL tie_completion: got timeout/ready-after %b expected 0000", {to0, to1, ra0, ra1});
    end
    checks++;
    if (p0 !== 32'hFFFFFFFE) begin
      errors++;
      $display("FAIL tie_req0_product: got %h expected fffffffe", p0);
    end
    checks++;
    if (p1 !== 32'd15) begin
      errors++;
      $display("FAIL tie_req1_product: got %0d expected 15", p1);
    end
    checks++;
    if (!(t0 < t1)) begin
      errors++;
      $display("FAIL tie_order: got req0 at %0d req1 at %0d expected req0 first", t0, t1);
    end
    checks++;
    if (grant_log.size() - base != 2 || grant_log[base] !== 1'b0 || grant_log[base+1] !== 1'b1) begin
      errors++;
      $display("FAIL tie_grant_seq: got %0d grants expected sequence 0,1", grant_log.size() - base);
    end
    checks++;
    if (req0_product !== 32'hFFFFFFFE) begin
      errors++;
      $display("FAIL tie_req0_hold: got %h expected fffffffe", req0_product);
    end
  endtask

  task automatic test_round_robin;
    int base;
    apply_reset();
    mul_lat = 2;
    base = grant_log.size();
    fork
      for (int i = 0; i < 2; i++) begin
        logic [31:0] a, b, p; logic [2:0] o; int tr; bit to; logic ra;
        a = $urandom; b = $urandom; o = 3'($urandom_range(0, 3));
        serve(0, a, b, o, p, tr, to, ra);
        checks++;
        if (to || p !== ref_mul(a, b, o)) begin
          errors++;
          $display("FAIL rr_req0_product: got %h expected %h", p, ref_mul(a, b, o));
        end
        @(posedge clk); #1;
      end
      for (int j = 0; j < 2; j++) begin
        logic [31:0] a, b, p; logic [2:0] o; int tr; bit to; logic ra;
        a = $urandom; b = $urandom; o = 3'($urandom_range(0, 3));
        serve(1, a, b, o, p, tr, to, ra);
        checks++;
        if (to || p !== ref_mul(a, b, o)) begin
          errors++;
          $display("FAIL rr_req1_product: got %h expected %h", p, ref_mul(a, b, o));
        end
        @(posedge clk); #1;
      end
    join
    checks++;
    if (grant_log.size() - base != 4) begin
      errors++;
      $display("FAIL rr_grant_count: got %0d expected 4", grant_log.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        logic e;
        e = (i % 2 == 1);
        checks++;
        if (grant_log[base+i] !== e) begin
          errors++;
          $display("FAIL rr_grant_%0d: got %b expected %b", i, grant_log[base+i], e);
        end
      end
    end
  endtask

  task automatic test_spurious;
    logic [31:0] a, b;
    logic [2:0] o;
    spur_cnt++;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({req0_ready, req1_ready, busy} !== 3'b0) begin
        errors++;
        $display("FAIL spur_idle: got ready0/ready1/busy %b expected 000", {req0_ready, req1_ready, busy});
      end
    end
    mul_lat = 3;
    a = $urandom; b = $urandom; o = 3'($urandom_range(0, 3));
    req1_factor1 = a; req1_factor2 = b; req1_op = o; req1_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      checks++;
      if (mul_valid !== (k == 1) || req1_ready !== (k == 5) || busy !== (k <= 5)) begin
        errors++;
        $display("FAIL spur_timing k=%0d: got valid/ready/busy %b%b%b expected %b%b%b",
                 k, mul_valid, req1_ready, busy, (k == 1), (k == 5), (k <= 5));
      end
      if (k <= 5) begin
        checks++;
        if ({mul_factor1, mul_factor2, mul_op} !== {a, b, o}) begin
          errors++;
          $display("FAIL spur_operands k=%0d: got %h expected %h", k, {mul_factor1, mul_factor2, mul_op}, {a, b, o});
        end
      end
      if (k == 5) begin
        checks++;
        if (req1_product !== ref_mul(a, b, o)) begin
          errors++;
          $display("FAIL spur_product: got %h expected %h", req1_product, ref_mul(a, b, o));
        end
      end
      if (k == 1 || k == 5) spur_cnt++;
      if (k == 6) req1_valid = 1'b0;
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] p;
    int tr;
    bit to;
    logic ra;
    mul_lat = 10;
    req1_factor1 = 32'hFFFFFFFE; req1_factor2 = 32'd3; req1_op = 3'd1; req1_valid = 1'b1;
    repeat (4) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    checks++;
    if ({busy, mul_valid, req0_ready, req1_ready, grant_id} !== 5'b0) begin
      errors++;
      $display("FAIL midreset_ctrl: got %b expected 00000", {busy, mul_valid, req0_ready, req1_ready, grant_id});
    end
    checks++;
    if ({req0_product, req1_product, mul_factor1, mul_factor2, mul_op} !== 131'd0) begin
      errors++;
      $display("FAIL midreset_data: got %h expected 0", {req0_product, req1_product, mul_factor1, mul_factor2, mul_op});
    end
    req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({req1_ready, busy} !== 2'b00) begin
        errors++;
        $display("FAIL midreset_quiet k=%0d: got ready1/busy %b expected 00", k, {req1_ready, busy});
      end
    end
    mul_lat = 3;
    serve(1, 32'hFFFFFFFE, 32'd3, 3'd1, p, tr, to, ra);
    checks++;
    if (to || p !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL midreset_retry: got %h timeout %b expected ffffffff", p, to);
    end
  endtask

  task automatic test_hold;
    logic [31:0] p;
    int tr;
    bit to, got;
    logic ra;
    mul_lat = 3;
    serve(1, 32'd3, 32'd5, 3'd0, p, tr, to, ra);
    checks++;
    if (to || p !== 32'd15 || ra !== 1'b0) begin
      errors++;
      $display("FAIL hold_req1_first: got %0d timeout %b pulse-after %b expected 15", p, to, ra);
    end
    got = 1'b0;
    req0_factor1 = 32'd7; req0_factor2 = 32'd6; req0_op = 3'd0; req0_valid = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      checks++;
      if (req1_ready !== 1'b0 || req1_product !== 32'd15) begin
        errors++;
        $display("FAIL hold_req1 k=%0d: got ready %b product %0d expected 0 and 15", k, req1_ready, req1_product);
      end
      if (req0_ready) begin
        got = 1'b1;
        checks++;
        if (req0_product !== 32'd42) begin
          errors++;
          $display("FAIL hold_req0_product: got %0d expected 42", req0_product);
        end
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL hold_req0_done: got no ready expected one ready pulse");
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    localparam int NOPS = 8;
    int n_done0, n_done1;
    n_done0 = 0;
    n_done1 = 0;
    apply_reset();
    mul_lat = 0;
    fork
      for (int i = 0; i < NOPS; i++) begin
        logic [31:0] a, b, p; logic [2:0] o; int tr; bit to; logic ra;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        a = $urandom; b = $urandom; o = 3'($urandom_range(0, 3));
        serve(0, a, b, o, p, tr, to, ra);
        checks++;
        if (to || ra !== 1'b0 || p !== ref_mul(a, b, o)) begin
          errors++;
          $display("FAIL rand_req0_op%0d: got %h timeout %b expected %h", i, p, to, ref_mul(a, b, o));
        end
      end
      for (int j = 0; j < NOPS; j++) begin
        logic [31:0] a, b, p; logic [2:0] o; int tr; bit to; logic ra;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        a = $urandom; b = $urandom; o = 3'($urandom_range(0, 3));
        serve(1, a, b, o, p, tr, to, ra);
        checks++;
        if (to || ra !== 1'b0 || p !== ref_mul(a, b, o)) begin
          errors++;
          $display("FAIL rand_req1_op%0d: got %h timeout %b expected %h", j, p, to, ref_mul(a, b, o));
        end
      end
      begin
        bit issue_next;
        logic m_last, exp_g;
        logic [31:0] c1, c2, last_p0, last_p1;
        logic [2:0] co;
        int guard;
        issue_next = 1'b0; m_last = 1'b1; exp_g = 1'b0;
        c1 = 32'd0; c2 = 32'd0; co = 3'd0; last_p0 = 32'd0; last_p1 = 32'd0; guard = 0;
        while ((n_done0 + n_done1) < 2 * NOPS && guard < 4000) begin
          @(negedge clk);
          guard++;
          if (issue_next) begin
            issue_next = 1'b0;
            checks++;
            if (mul_valid !== 1'b1 || grant_id !== exp_g || {mul_factor1, mul_factor2, mul_op} !== {c1, c2, co}) begin
              errors++;
              $display("FAIL rand_issue: got valid %b grant %b ops %h expected 1 %b %h",
                       mul_valid, grant_id, {mul_factor1, mul_factor2, mul_op}, exp_g, {c1, c2, co});
            end
          end else begin
            checks++;
            if (mul_valid !== 1'b0) begin
              errors++;
              $display("FAIL rand_stray_valid: got %b expected 0", mul_valid);
            end
            if (!busy && (req0_valid || req1_valid)) begin
              exp_g = (req0_valid && req1_valid) ? ~m_last : req1_valid;
              m_last = exp_g;
              c1 = exp_g ? req1_factor1 : req0_factor1;
              c2 = exp_g ? req1_factor2 : req0_factor2;
              co = exp_g ? req1_op : req0_op;
              issue_next = 1'b1;
            end
          end
          if (req0_ready) begin
            checks++;
            if (exp_g !== 1'b0 || req1_ready !== 1'b0 || req0_product !== ref_mul(c1, c2, co) || req1_product !== last_p1) begin
              errors++;
              $display("FAIL rand_resp0: got p0 %h p1 %h expected %h %h", req0_product, req1_product, ref_mul(c1, c2, co), last_p1);
            end
            last_p0 = ref_mul(c1, c2, co);
            n_done0++;
          end
          if (req1_ready) begin
            checks++;
            if (exp_g !== 1'b1 || req0_ready !== 1'b0 || req1_product !== ref_mul(c1, c2, co) || req0_product !== last_p0) begin
              errors++;
              $display("FAIL rand_resp1: got p1 %h p0 %h expected %h %h", req1_product, req0_product, ref_mul(c1, c2, co), last_p0);
            end
            last_p1 = ref_mul(c1, c2, co);
            n_done1++;
          end
        end
      end
    join
    checks++;
    if (n_done0 != NOPS || n_done1 != NOPS) begin
      errors++;
      $display("FAIL rand_counts: got %0d/%0d completions expected %0d each", n_done0, n_done1, NOPS);
    end
  endtask

  initial begin
    resetn = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_factor1 = 32'd0; req0_factor2 = 32'd0; req0_op = 3'd0;
    req1_factor1 = 32'd0; req1_factor2 = 32'd0; req1_op = 3'd0;
    test_reset();
    test_basic();
    test_tie();
    test_round_robin();
    test_spurious();
    test_reset_mid();
    test_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter: OP_W, 3, width of multiplier operation code.
REQ-002 Reset resetn, asynchronous, active-low; clock clk.
REQ-003 clk  input  1  system clock, all state on rising edge.
REQ-004 resetn  input  1  asynchronous active-low reset.
REQ-005 reqN_valid  input  1  (N=0,1) requester N has an operation pending.
REQ-006 reqN_factor1, reqN_factor2  input  32  requester N operands.
REQ-007 reqN_op  input  OP_W  requester N MUL/MULH/MULHSU/MULHU code.
REQ-008 reqN_ready  output  1  one-cycle completion pulse to requester N.
REQ-009 reqN_product  output  32  result for requester N.
REQ-010 mul_valid  output  1  start strobe to the shared multiplier.
REQ-011 mul_factor1, mul_factor2  output  32  operands to the multiplier.
REQ-012 mul_op  output  OP_W  operation code to the multiplier.
REQ-013 mul_product  input  32  multiplier result.
REQ-014 mul_ready  input  1  multiplier completion pulse.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 grant_id  output  1  index of the current or most recent grant.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT, RESP, one-hot encoded.
REQ-018 IDLE: if any reqN_valid, grant, latch that requester's factors and op into holding registers, go to ISSUE.
REQ-019 Arbitration is round-robin: a single requester wins; when both are valid, the requester not granted last time wins; last-grant resets to 1, so req0 wins the first tie.
REQ-020 ISSUE: mul_valid=1 for exactly this one cycle, then go to WAIT.
REQ-021 mul_valid is 0 in every state other than ISSUE.
REQ-022 mul_factor1, mul_factor2 and mul_op are driven from the holding registers and stay stable from ISSUE through the RESP cycle, because the multiplier reads them until its ready cycle.
REQ-023 WAIT: on mul_ready=1, register mul_product into the granted reqN_product and go to RESP.
REQ-024 RESP: the granted reqN_ready=1 for exactly one cycle, then go to IDLE.
REQ-025 reqN_valid is ignored in RESP.
REQ-026 Requester protocol:
 - valid is held, with stable operands, until ready is seen.
 - valid is dropped in the cycle after ready.
REQ-027 Latency: if the multiplier raises mul_ready L cycles after the ISSUE cycle, reqN_ready rises L+1 cycles after ISSUE; ISSUE is the cycle after the grant.
REQ-028 Only the granted requester's product register and ready change; the other reqN_product holds its value.
REQ-029 reqN_product holds its last result until that requester's next completion.
REQ-030 mul_ready seen in IDLE, ISSUE or RESP is ignored and has no side effects.
REQ-031 If the granted reqN_valid drops before completion (a protocol violation), the operation still completes and reqN_ready still pulses.
REQ-032 Exactly one operation is outstanding at the multiplier at any time; there is no queueing beyond the two request ports.
REQ-033 A request arriving at the other port while busy waits; it is granted in the first IDLE cycle after RESP.

Reset
REQ-034 On resetn=0, immediately:
 - state=IDLE, last-grant=1, grant_id=0;
 - busy=0, mul_valid=0, reqN_ready=0;
 - reqN_product=0 and holding registers=0.
REQ-035 Reset mid-operation abandons the operation with no ready pulse; the multiplier is reset by the same resetn.

Verification
REQ-036 req0_valid=1, factor1=7, factor2=6, op=MUL, serial multiplier.
 - Expected: mul_valid one cycle later for one cycle.
 - Expected: req0_ready=1 in cycle T+36 (valid first high in cycle T) with req0_product=42, in a single-cycle pulse.
REQ-037 Both requests valid in the same IDLE cycle after reset (req0 MULHU 0xFFFFFFFF*0xFFFFFFFF, req1 MUL 3*5).
 - Expected: req0 served first with product 0xFFFFFFFE.
 - Expected: req1 served next with product 15.
 - Expected: grant_id sequence 0,1.
REQ-038 Both requesters continuously re-request for 4 operations.
 - Expected: grants alternate 0,1,0,1.
 - Expected: never two consecutive grants to the same requester.
REQ-039 Multiplier model raises a spurious mul_ready in IDLE, then real ops use latency L=3.
 - Expected: no reqN_ready from the spurious pulse.
 - Expected: reqN_ready 4 cycles after ISSUE.
 - Expected: operands stable from ISSUE through RESP.
REQ-040 resetn asserted during WAIT of a req1 MULH (-2)*3.
 - Expected: all outputs at reset values, and no req1_ready.
 - Expected: after release, a fresh req1 MULH (-2)*3 yields 0xFFFFFFFF.
REQ-041 req1 completes with 15, then req0 completes with 42.
 - Expected: req1_product still 15 and req1_ready stays 0 throughout req0's operation.
